data_memory_mmio: RTL and testbench
===================================

# data_memory_mmio

Word-organised data memory with byte-lane writes and a memory-mapped peripheral window, used in the MEM stage of the pipelined processor. It replaces the fixed-size data memory with a parametrised RAM, byte enables for sb/sh, a registered LED/7-segment output block, a free-running cycle counter and an optional reload timer that raises an interrupt request. Reads are combinational and writes take effect on the clock edge.

## Interface
- RAM_WORDS, 512: number of 32-bit RAM words; must be a power of two.
- ADDR_BITS, 9: log2(RAM_WORDS); word index = addr[ADDR_BITS+1:2].
- LED_W, 8: width of the LED register.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address. addr[30]=1 selects the peripheral window; addr[30]=0 selects RAM.
- wdata  in  32  write data, lane-aligned (byte k on bits 8k+7:8k).
- byte_en  in  4  write lane enables; 4'b1111 for sw.
- mem_read  in  1  read strobe.
- mem_write  in  1  write strobe.
- rdata  out  32  read data; combinational.
- led  out  LED_W  LED register.
- digi  out  12  7-segment drive register.
- irq  out  1  timer interrupt request, equal to TCON[2].

## Operation
- RAM
  - Window: addr[30]=0.
  - Address is in range when addr[29:ADDR_BITS+2]==0.
  - Write: when mem_write=1 and the address is in range, each lane k with byte_en[k]=1 is written and the other lanes are preserved.
  - Read: returns the word when mem_read=1 and the address is in range; otherwise 0.
  - Out-of-range access: writes are ignored and reads return 0.
  - RAM contents are not affected by reset.
- Peripheral window (addr[30]=1), decoded on addr[7:0]. byte_en is ignored; every peripheral write is a full register write.
  - 0x00 TH: reload value, RW.
  - 0x04 TL: counter, RW.
  - 0x08 TCON: RW, bits[2:0]; bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status. Upper read bits are 0.
  - 0x0C LED: RW, written from wdata[LED_W-1:0], read zero-extended.
  - 0x10 DIGI: RW, written from wdata[11:0], read zero-extended.
  - 0x14 SYSTICK: read-only; writes are ignored.
  - Any other offset: reads 0, writes ignored.
  - Peripheral reads also require mem_read=1; otherwise rdata=0.
- SYSTICK: 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0.
- Timer, each cycle:
  - If TCON[0]=1 and TL!=0xFFFFFFFF: TL increments.
  - If TCON[0]=1 and TL==0xFFFFFFFF: TL<=TH, and if TCON[1]=1, TCON[2]<=1.
  - If TCON[0]=0: TL holds.
- Clearing irq: software writes TCON with bit2=0.
- Simultaneous events: a software write to TL or TCON in the same cycle as an overflow wins. The written value is taken, no reload occurs, and TCON[2] takes wdata[2].

## Timing
- Reset values: TH=0, TL=0, TCON=0, LED=0, DIGI=12'hFFF (display blank), SYSTICK=0, irq=0.
- rdata is combinational from addr, mem_read and current state, with zero cycles of latency.
- A write at edge N is visible to a read in cycle N+1.
- Read-during-write to the same word returns the old value before the edge.
- Overflow timing: TL==0xFFFFFFFF in cycle N gives TL=TH and irq=1 in cycle N+1, when TCON=3'b011.
- Reset asserted mid-count clears all peripheral state immediately (asynchronous).
- RAM keeps its contents through reset, including a write in flight: a write on an edge while reset is asserted is not performed.

## Configuration
- TIMER_EN:
  - Defined: TH, TL, TCON and irq are implemented as above.
  - Undefined: no timer registers exist; offsets 0x00–0x08 read 0 and ignore writes; irq is tied to 0.
  - SYSTICK, LED, DIGI and RAM are identical in both builds.

## Test plan
- Reset, then read LED, DIGI, SYSTICK on the first cycle after reset -> 0x0, 0xFFF, 0x0; irq=0.
- sw 0x11223344 to 0x10, then sb 0xAA on lane 1 (byte_en=4'b0010) to 0x10, then lw 0x10 -> 0x1122AA44.
- RAM_WORDS=512: sw 0xDEADBEEF to 0x800 (out of range), then lw 0x800 -> 0x0; lw 0x0 unchanged.
- TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> irq rises 2 cycles later with TL=0xFFFFFFF0; write TCON=3 -> irq falls next cycle and counting continues.
- Set TL=0xFFFFFFFF with TCON=3; in the overflow cycle write TL=0x5 -> TL=0x6 next cycle, irq stays 0.
- Build without TIMER_EN: write TCON=3, TL=0xFFFFFFFF -> reads of 0x08 and 0x04 return 0; irq stays 0 for 10 cycles.

Source files
------------

// File: rtl/data_memory_mmio_if.sv
// data_memory_mmio_if: MEM-stage bus between the core and the data memory / MMIO block
interface data_memory_mmio_if #(parameter int LED_W = 8);
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0] byte_en;
  logic mem_read;
  logic mem_write;
  logic [31:0] rdata;
  logic [LED_W-1:0] led;
  logic [11:0] digi;
  logic irq;
  modport master(output addr, wdata, byte_en, mem_read, mem_write, input rdata, led, digi, irq);
  modport slave(input addr, wdata, byte_en, mem_read, mem_write, output rdata, led, digi, irq);
endinterface

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: byte-lane RAM plus LED/DIGI/SYSTICK MMIO; reload timer with irq only when TIMER_EN is defined
module data_memory_mmio #(
  parameter int RAM_WORDS = 512,
  parameter int ADDR_BITS = 9,
  parameter int LED_W = 8
) (
  input logic clk,
  input logic reset,
  data_memory_mmio_if.slave bus
);
  logic [31:0] ram [RAM_WORDS];
  logic per, in_range, per_we;
  logic [ADDR_BITS-1:0] idx;
  logic [7:0] off;
  logic [31:0] systick, th, tl, per_rd;
  logic [2:0] tcon;
  logic [LED_W-1:0] led_q;
  logic [11:0] digi_q;
  logic unused_addr;
  assign per = bus.addr[30];
  assign in_range = bus.addr[29:ADDR_BITS+2] == '0;
  assign idx = bus.addr[ADDR_BITS+1:2];
  assign off = bus.addr[7:0];
  assign per_we = bus.mem_write && per;
  assign unused_addr = ^{bus.addr[31], bus.addr[1:0]};
  // RAM has no reset, but a write coinciding with reset must not land
  always_ff @(posedge clk)
    if (!reset && bus.mem_write && !per && in_range)
      for (int k = 0; k < 4; k++)
        if (bus.byte_en[k]) ram[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      systick <= '0;
      led_q <= '0;
      digi_q <= 12'hFFF;
    end else begin
      systick <= systick + 32'd1;
      if (per_we && off == 8'h0C) led_q <= bus.wdata[LED_W-1:0];
      if (per_we && off == 8'h10) digi_q <= bus.wdata[11:0];
    end
`ifdef TIMER_EN
  logic wr_th, wr_tl, wr_tcon, tl_max, ovf;
  assign wr_th = per_we && off == 8'h00;
  assign wr_tl = per_we && off == 8'h04;
  assign wr_tcon = per_we && off == 8'h08;
  assign tl_max = &tl;
  // a software write to TL or TCON preempts the reload and the irq set
  assign ovf = tcon[0] && tl_max && !wr_tl && !wr_tcon;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      th <= '0;
      tl <= '0;
      tcon <= '0;
    end else begin
      if (wr_th) th <= bus.wdata;
      tl <= wr_tl ? bus.wdata : ovf ? th : (tcon[0] && !tl_max) ? tl + 32'd1 : tl;
      tcon <= wr_tcon ? bus.wdata[2:0] : {tcon[2] | (ovf & tcon[1]), tcon[1:0]};
    end
`else
  assign th = '0;
  assign tl = '0;
  assign tcon = '0;
`endif
  assign bus.irq = tcon[2];
  assign bus.led = led_q;
  assign bus.digi = digi_q;
  assign per_rd = off == 8'h00 ? th :
                  off == 8'h04 ? tl :
                  off == 8'h08 ? {29'd0, tcon} :
                  off == 8'h0C ? 32'(led_q) :
                  off == 8'h10 ? {20'd0, digi_q} :
                  off == 8'h14 ? systick : '0;
  assign bus.rdata = !bus.mem_read ? '0 : per ? per_rd : in_range ? ram[idx] : '0;
endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: scoreboard bench for RAM lanes, range checks, MMIO registers, reset and the timer build option
module tb_data_memory_mmio;
  localparam logic [31:0] TH = 32'h4000_0000, TL = 32'h4000_0004, TCON = 32'h4000_0008;
  localparam logic [31:0] LED = 32'h4000_000C, DIGI = 32'h4000_0010, STK = 32'h4000_0014;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$], obs_q[$];
  string tag_q[$];
  logic [31:0] cyc;
  always #5 clk = ~clk;
  data_memory_mmio_if #(.LED_W(8)) bus();
  data_memory_mmio #(.RAM_WORDS(512), .ADDR_BITS(9), .LED_W(8)) dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always @(posedge clk or posedge reset) cyc <= reset ? 32'd0 : cyc + 32'd1;
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr = a; bus.wdata = d; bus.byte_en = be; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e); tag_q.push_back(t);
    bus.addr = a; bus.mem_read = 1'b1;
    #1 obs_q.push_back(bus.rdata);
    bus.mem_read = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] e, o;
    string t;
    rd(LED, 32'h0, "reset_led"); rd(DIGI, 32'hFFF, "reset_digi"); rd(STK, 32'h0, "reset_systick");
    checks += 3;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    if (bus.led !== 8'h00) begin errors++; $display("FAIL reset_led_port: got %h expected 00", bus.led); end
    if (bus.digi !== 12'hFFF) begin errors++; $display("FAIL reset_digi_port: got %h expected fff", bus.digi); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
  task automatic test_ram_bytes;
    logic [31:0] e, o;
    string t;
    wr(32'h10, 32'h1122_3344, 4'b1111); wr(32'h10, 32'h0000_AA00, 4'b0010);
    rd(32'h10, 32'h1122_AA44, "sb_lane1");
    wr(32'h14, 32'h0102_0304, 4'b1111); wr(32'h14, 32'hBEEF_0000, 4'b1100);
    rd(32'h14, 32'hBEEF_0304, "sh_upper");
    bus.addr = 32'h10; bus.mem_read = 1'b0;
    #1 checks++;
    if (bus.rdata !== 32'h0) begin errors++; $display("FAIL no_read_strobe: got %h expected 0", bus.rdata); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
  task automatic test_out_of_range;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(32'h0, 32'h1234_5678, 4'b1111); wr(32'h800, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h800, 32'h0, "oor_read"); rd(32'h0, 32'h1234_5678, "oor_no_alias");
    rd(32'h2000_0010, 32'h0, "oor_high_bit");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
  task automatic test_peripherals;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(LED, 32'h1234_5678, 4'b0000); wr(DIGI, 32'h000A_BCDE, 4'b0001); wr(STK, 32'h0000_FFFF, 4'b1111);
    checks += 2;
    if (bus.led !== 8'h78) begin errors++; $display("FAIL led_port: got %h expected 78", bus.led); end
    if (bus.digi !== 12'hCDE) begin errors++; $display("FAIL digi_port: got %h expected cde", bus.digi); end
    rd(LED, 32'h78, "led_read"); rd(DIGI, 32'hCDE, "digi_read");
    rd(STK, cyc, "systick_read"); rd(32'h4000_0018, 32'h0, "unmapped_read");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
  task automatic test_read_during_write;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(32'h20, 32'hAAAA_5555, 4'b1111);
    bus.addr = 32'h20; bus.wdata = 32'h1234_5678; bus.byte_en = 4'b1111; bus.mem_write = 1'b1; bus.mem_read = 1'b1;
    exp_q.push_back(32'hAAAA_5555); tag_q.push_back("rdw_old");
    #1 obs_q.push_back(bus.rdata);
    @(negedge clk);
    bus.mem_write = 1'b0;
    exp_q.push_back(32'h1234_5678); tag_q.push_back("rdw_new");
    #1 obs_q.push_back(bus.rdata);
    bus.mem_read = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
`ifdef TIMER_EN
  task automatic test_timer_overflow;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(TH, 32'hFFFF_FFF0, 4'b1111); wr(TL, 32'hFFFF_FFFE, 4'b1111); wr(TCON, 32'h3, 4'b1111);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_before_1: got %b expected 0", bus.irq); end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_before_2: got %b expected 0", bus.irq); end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", bus.irq); end
    rd(TL, 32'hFFFF_FFF0, "tl_reload"); rd(TCON, 32'h7, "tcon_status");
    wr(TCON, 32'h3, 4'b1111);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", bus.irq); end
    rd(TL, 32'hFFFF_FFF1, "tl_count_1");
    @(negedge clk);
    rd(TL, 32'hFFFF_FFF2, "tl_count_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
  task automatic test_overflow_write;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(TCON, 32'h0, 4'b1111); wr(TL, 32'hFFFF_FFFF, 4'b1111); wr(TH, 32'h100, 4'b1111);
    wr(TCON, 32'h3, 4'b1111); wr(TL, 32'h5, 4'b1111);
    rd(TL, 32'h5, "ovf_write_tl");
    @(negedge clk);
    rd(TL, 32'h6, "ovf_write_next"); rd(TCON, 32'h3, "ovf_write_tcon");
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL ovf_write_irq: got %b expected 0", bus.irq); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
`else
  task automatic test_no_timer;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(TCON, 32'h3, 4'b1111); wr(TL, 32'hFFFF_FFFF, 4'b1111); wr(TH, 32'h55, 4'b1111);
    rd(TCON, 32'h0, "no_timer_tcon"); rd(TL, 32'h0, "no_timer_tl"); rd(TH, 32'h0, "no_timer_th");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL no_timer_irq: cycle %0d got %b expected 0", i, bus.irq); end
    end
  endtask
`endif
  task automatic test_async_reset;
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    wr(32'h30, 32'h0BAD_F00D, 4'b1111); wr(LED, 32'h5A, 4'b1111);
    #2 reset = 1'b1;
    #1 checks += 2;
    if (bus.led !== 8'h00) begin errors++; $display("FAIL async_led: got %h expected 00", bus.led); end
    if (bus.digi !== 12'hFFF) begin errors++; $display("FAIL async_digi: got %h expected fff", bus.digi); end
    wr(32'h30, 32'hFFFF_FFFF, 4'b1111);
    reset = 1'b0;
    rd(32'h30, 32'h0BAD_F00D, "ram_kept"); rd(STK, 32'h0, "async_systick"); rd(TL, 32'h0, "async_tl");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    bus.addr = '0; bus.wdata = '0; bus.byte_en = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_ram_bytes;
    test_out_of_range;
    test_peripherals;
    test_read_during_write;
`ifdef TIMER_EN
    test_timer_overflow;
    test_overflow_write;
`else
    test_no_timer;
`endif
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
